// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding and the word-alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
// A request stays up with a stable address until the memory acknowledges it.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_timeout.sv
// Saturating acknowledge-wait counter with a sticky timeout flag.
// The counter restarts every time the fetch unit enters FETCH; only reset clears the flag.
module fetch_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_fetch,
    input  logic ack,
    output logic fetch_err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt_d, wait_cnt_q;
    logic             err_d, err_q;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        // Outside FETCH the counter idles at zero, so every new fetch starts a fresh count.
        if (!in_fetch) begin
            wait_cnt_d = '0;
        end else if (!ack && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        if (in_fetch && (wait_cnt_d == CNT_MAX)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign fetch_err = err_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word, holds it until the consumer takes it,
// then fetches sequentially or from a redirect target. Ack timeouts raise a sticky error.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_if.master      imem,
    output logic [31:0]  Instr,
    output logic         instr_valid,
    input  logic         stall,
    input  logic         PCSrc,
    input  logic [31:0]  Result,
    output logic [31:0]  PCPlus8,
    output logic         fetch_err
);

    fetch_state_e state_d, state_q;
    logic [31:0]  pc_d, pc_q;
    logic [31:0]  pc_instr_d, pc_instr_q;
    logic [31:0]  instr_d, instr_q;
    logic         in_fetch;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_instr_d = pc_instr_q;
        instr_d    = instr_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    instr_d    = imem.imem_rdata;
                    pc_instr_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                // PCSrc/Result only matter on the cycle the held instruction is consumed.
                if (!stall) begin
                    state_d = FETCH;
                    if (PCSrc) begin
                        pc_d = word_align(Result);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pc_instr_q <= RESET_PC;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_instr_q <= pc_instr_d;
            instr_q    <= instr_d;
        end
    end

    // Outputs decode straight from registered state so reset drops the request at once.
    assign in_fetch       = (state_q == FETCH);
    assign imem.imem_req  = in_fetch;
    assign imem.imem_addr = word_align(pc_q);
    assign instr_valid    = (state_q == HOLD);
    assign Instr          = instr_q;
    assign PCPlus8        = pc_instr_q + 32'd8;

    fetch_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .in_fetch  (in_fetch),
        .ack       (imem.imem_ack),
        .fetch_err (fetch_err)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a behavioural fetch model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        PCSrc;
    logic [31:0] Result;
    logic [31:0] Instr;
    logic        instr_valid;
    logic [31:0] PCPlus8;
    logic        fetch_err;

    fetch_if bus ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus),
        .Instr       (Instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .PCSrc       (PCSrc),
        .Result      (Result),
        .PCPlus8     (PCPlus8),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: "started" = one cycle out of reset, "have" = an instruction is held.
    bit          m_started;
    bit          m_have;
    bit          m_err;
    int          m_wait;
    logic [31:0] m_pc;
    logic [31:0] m_pc_instr;
    logic [31:0] m_instr;

    task automatic model_reset();
        m_started  = 1'b0;
        m_have     = 1'b0;
        m_err      = 1'b0;
        m_wait     = 0;
        m_pc       = RESET_PC;
        m_pc_instr = RESET_PC;
        m_instr    = 32'h0;
    endtask

    task automatic model_step(input bit ack, input logic [31:0] rdata, input bit st,
                              input bit src, input logic [31:0] res);
        if (!m_started) begin
            m_started = 1'b1;
            m_wait    = 0;
        end else if (!m_have) begin
            if (ack) begin
                m_instr    = rdata;
                m_pc_instr = m_pc;
                m_pc       = m_pc + 32'd4;
                m_have     = 1'b1;
            end else begin
                if (m_wait < TIMEOUT) m_wait = m_wait + 1;
                if (m_wait >= TIMEOUT) m_err = 1'b1;
            end
        end else if (!st) begin
            m_have = 1'b0;
            m_wait = 0;
            if (src) m_pc = {res[31:2], 2'b00};
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_model();
        chk("imem_req",    32'(bus.imem_req),  32'(m_started && !m_have));
        chk("instr_valid", 32'(instr_valid),   32'(m_have));
        chk("fetch_err",   32'(fetch_err),     32'(m_err));
        chk("Instr",       Instr,              m_instr);
        chk("PCPlus8",     PCPlus8,            m_pc_instr + 32'd8);
        if (m_started && !m_have) chk("imem_addr", bus.imem_addr, {m_pc[31:2], 2'b00});
    endtask

    task automatic cycle(input bit ack, input logic [31:0] rdata, input bit st,
                         input bit src, input logic [31:0] res);
        bus.imem_ack   = ack;
        bus.imem_rdata = rdata;
        stall          = st;
        PCSrc          = src;
        Result         = res;
        @(posedge clk);
        if (reset) model_step(ack, rdata, st, src, res);
        else       model_reset();
        #1;
        check_model();
    endtask

    initial begin
        reset          = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        stall          = 1'b0;
        PCSrc          = 1'b0;
        Result         = 32'h0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("rst_pcplus8", PCPlus8, RESET_PC + 32'd8);

        // Release: IDLE this cycle, request from RESET_PC the next
        reset = 1'b1;
        #1;
        chk("idle_req", 32'(bus.imem_req), 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("c1_req",  32'(bus.imem_req), 32'd1);
        chk("c1_addr", bus.imem_addr, 32'h0);
        cycle(1'b1, 32'hE3A0_1005, 1'b0, 1'b0, 32'h0);
        chk("c2_valid", 32'(instr_valid), 32'd1);
        chk("c2_instr", Instr, 32'hE3A0_1005);
        chk("c2_pc8",   PCPlus8, 32'd8);

        // Stall 3 cycles with a redirect offered that must be ignored
        repeat (3) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0055);
            chk("stall_instr", Instr, 32'hE3A0_1005);
            chk("stall_req",   32'(bus.imem_req), 32'd0);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("seq_addr", bus.imem_addr, 32'h4);

        // Redirect only on consume
        cycle(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200);
        chk("nored_valid", 32'(instr_valid), 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
        chk("redir_addr", bus.imem_addr, 32'h0000_0100);

        // Ack delayed 5 cycles
        repeat (5) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk("dly_addr", bus.imem_addr, 32'h0000_0100);
            chk("dly_err",  32'(fetch_err), 32'd0);
        end
        cycle(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Ack withheld past TIMEOUT; request continues, error sticks after a late ack
        repeat (TIMEOUT - 1) cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("to_pre_err", 32'(fetch_err), 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("to_err", 32'(fetch_err), 32'd1);
        repeat (3) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk("to_req", 32'(bus.imem_req), 32'd1);
        end
        cycle(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        chk("to_err_sticky", 32'(fetch_err), 32'd1);

        // PC wrap from 32'hFFFF_FFFC
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("wrap_addr_hi", bus.imem_addr, 32'hFFFF_FFFC);
        cycle(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
        chk("wrap_pc8", PCPlus8, 32'h0000_0004);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr_lo", bus.imem_addr, 32'h0);

        // Reset mid-FETCH: request drops at once, late ack ignored
        reset = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
        chk("mid_rst_err", 32'(fetch_err), 32'd0);
        model_reset();
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        chk("late_ack_valid", 32'(instr_valid), 32'd0);
        reset = 1'b1;
        #1;
        chk("restart_idle", 32'(bus.imem_req), 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("restart_addr", bus.imem_addr, RESET_PC);

        // Randomized traffic against the model
        repeat (400) begin
            cycle(($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter TIMEOUT, default 16: cycles without imem_ack before fetch_err is raised.
REQ-003 SHALL have port clk  input  1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port imem_req  output  1: instruction memory read request.
REQ-006 SHALL have port imem_addr  output  32: word-aligned fetch address.
REQ-007 SHALL have port imem_ack  input  1: read complete; imem_rdata is valid in the same cycle.
REQ-008 SHALL have port imem_rdata  input  32: fetched instruction word.
REQ-009 SHALL have port Instr  output  32: held instruction; the decode/controller stage consumes bits [31:12].
REQ-010 SHALL have port instr_valid  output  1: Instr is valid for consumption.
REQ-011 SHALL have port stall  input  1: consumer is not ready; Instr is held.
REQ-012 SHALL have port PCSrc  input  1: taken branch or PC write from the consumed instruction.
REQ-013 SHALL have port Result  input  32: redirect target; sampled only when PCSrc is honoured.
REQ-014 SHALL have port PCPlus8  output  32: address of the held instruction + 8 (R15 read value).
REQ-015 SHALL have port fetch_err  output  1: sticky flag for an acknowledge timeout.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH and HOLD.
REQ-017 SHALL make the IDLE->FETCH transition unconditionally one cycle after reset deasserts.
REQ-018 SHALL drive imem_req=1 only in FETCH, with imem_addr={pc[31:2],2'b00} held stable until imem_ack.
REQ-019 SHALL, on FETCH with imem_ack=1: Instr<=imem_rdata, pc_instr<=pc, pc<=pc+4 (mod 2^32), next state HOLD.
REQ-020 SHALL drive instr_valid=1 exactly in HOLD.
REQ-021 SHALL define consume as HOLD with stall=0.
REQ-022 SHALL, on consume, set next state FETCH and pc<=PCSrc ? {Result[31:2],2'b00} : pc.
REQ-023 SHALL ignore PCSrc and Result in any cycle that is not a consume.
REQ-024 SHALL hold Instr, pc and pc_instr unchanged while in HOLD with stall=1.
REQ-025 SHALL give latency: ack in cycle N -> instr_valid=1 in N+1; consume in M -> imem_req=1 in M+1.
REQ-026 SHALL give a zero-wait memory (ack with req) a throughput of 1 instruction per 2 cycles.
REQ-027 SHALL compute PCPlus8 = pc_instr+8 combinationally, with 32-bit wrap.
REQ-028 SHALL count wait cycles: counter clears on entry to FETCH, increments each FETCH cycle with imem_ack=0, and saturates at TIMEOUT.
REQ-029 SHALL set fetch_err sticky when the wait counter reaches TIMEOUT, and SHALL keep requesting after that.
REQ-030 SHALL clear fetch_err only by reset.
REQ-031 SHALL wrap pc from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-032 SHALL, while reset=0 (asynchronously): state=IDLE, pc=RESET_PC, pc_instr=RESET_PC, Instr=0, wait counter=0, fetch_err=0.
REQ-033 SHALL hold imem_req=0 and instr_valid=0 while reset=0, so PCPlus8=RESET_PC+8.
REQ-034 SHALL, on reset mid-FETCH, drop the outstanding request immediately and ignore any late imem_ack.
REQ-035 SHALL, on reset deassertion, restart from RESET_PC via IDLE.

Structure
REQ-036 SHALL place the state enum (IDLE/FETCH/HOLD) and a 32-bit word-alignment mask constant in a shared package fetch_pkg.
REQ-037 SHALL implement the saturating wait counter plus sticky error as the single sub-module fetch_timeout.
REQ-038 SHALL have no other sub-modules and SHALL use one clock domain.

Verification
REQ-039 Bench SHALL cover reset release, zero-wait memory with mem[0]=32'hE3A0_1005 -> imem_req cycle 1 addr 0, instr_valid cycle 2, Instr=32'hE3A0_1005, PCPlus8=8.
REQ-040 Bench SHALL cover stall=1 for 3 cycles in HOLD -> Instr/instr_valid held, imem_req=0, next fetch addr 4 after release.
REQ-041 Bench SHALL cover consume with PCSrc=1, Result=32'h0000_0103 -> next imem_addr=32'h0000_0100; PCSrc=1 with stall=1 -> no redirect.
REQ-042 Bench SHALL cover ack delayed 5 cycles -> imem_addr stable throughout, fetch_err=0; ack withheld 16 cycles -> fetch_err=1 and remains set after a later ack.
REQ-043 Bench SHALL cover reset=0 mid-FETCH -> imem_req=0 that cycle, restart at RESET_PC, fetch_err=0.
REQ-044 Bench SHALL cover pc=32'hFFFF_FFFC fetch -> next imem_addr=0, PCPlus8=32'h0000_0004.
